if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit, 5-stage pipeline. Sits directly upstream of the decode stage.
- Owns the PC, drives the instruction-memory read port, and holds the IF/ID pipeline register (instruction, PC+1, valid).
- Honours the decode stage's load-use bubble (stall), redirects from resolved branches/JAL/JR (flush), and stops fetching after a HLT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hB000, instruction injected on flush/stall-drain/halt. It is LLB R0,0: writes hardwired-zero R0, no flag update.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  16  word address to instruction memory; always equals pc.
- imem_re  output  1  fetch request; 1 in RUN, 0 in HALTED.
- imem_data  input  16  instruction word for imem_addr.
- imem_rdy  input  1  imem_data valid this cycle; 0 means miss/wait.
- stall  input  1  decode-stage bubble; hold PC and IF/ID.
- redirect  input  1  taken branch/JAL/JR resolved downstream.
- redirect_pc  input  16  target PC for redirect.
- pc  output  16  current fetch PC.
- IF_ID_instr  output  16  registered instruction to decode.
- IF_ID_pc_plus1  output  16  registered address of fetched instr + 1.
- IF_ID_valid  output  1  IF_ID_instr is a real fetched instruction.
- halted  output  1  state == HALTED.
- fetch_cnt  output  16  count of instructions delivered with valid=1.

Behaviour:
States:
- RUN: normal fetch.
- HALTED: a HLT was accepted into IF/ID; no further fetches.

Reset (rst=1 at clock edge):
- pc=RESET_PC, IF_ID_instr=NOP_INSTR, IF_ID_pc_plus1=0, IF_ID_valid=0, fetch_cnt=0, state=RUN.

Per-cycle priority: rst > redirect > stall > imem_rdy > normal.

- redirect=1 (any state):
  - pc<=redirect_pc; IF/ID<=NOP_INSTR with valid=0; state<=RUN.
  - Overrides a simultaneous stall.
  - Squashes a wrong-path HLT, whether in IF/ID or being fetched this cycle.
- stall=1, no redirect:
  - pc, IF_ID_*, fetch_cnt and state all hold.
  - imem_re stays as per state; returned data is discarded.
- RUN, imem_rdy=0:
  - pc holds.
  - IF/ID<=NOP_INSTR with valid=0 (bubble inserted downstream).
- RUN, imem_rdy=1:
  - IF_ID_instr<=imem_data; IF_ID_pc_plus1<=pc+1; IF_ID_valid<=1; fetch_cnt<=fetch_cnt+1.
  - If imem_data[15:12]==4'b1111 (HLT): pc holds and state<=HALTED.
  - Otherwise pc<=pc+1.
- HALTED, no redirect:
  - pc holds; imem_re=0.
  - IF/ID<=NOP_INSTR with valid=0, unless stall, in which case IF/ID holds so the HLT still reaches decode.
- Arithmetic:
  - pc+1 wraps modulo 2^16 (16'hFFFF -> 16'h0000); IF_ID_pc_plus1 wraps the same way.
  - fetch_cnt wraps modulo 2^16.
- Latency:
  - One cycle from imem_data to IF_ID_instr.
  - Redirect target is fetched on the cycle after redirect is asserted.
- Outputs are registered, except imem_addr, imem_re and halted, which are derived combinationally from pc/state.

Test Plan:
- Reset then 3 cycles with imem_rdy=1 and data 16'h0123, 16'h2456, 16'h3789 -> IF_ID_instr follows one cycle later; IF_ID_pc_plus1=1,2,3; pc=3; fetch_cnt=3.
- stall=1 for 2 cycles at pc=5 -> pc stays 5; IF_ID_instr/pc_plus1 unchanged; fetch_cnt unchanged; fetch resumes at 5 when stall drops.
- redirect=1 with redirect_pc=16'h0040 while stall=1 at pc=7 -> next cycle pc=16'h0040, IF_ID_instr=16'hB000, IF_ID_valid=0.
- Fetch 16'hF000 at pc=9 -> IF_ID_instr=16'hF000, valid=1; pc stays 9; halted=1, imem_re=0; later cycles give NOP with valid=0. redirect_pc=16'h0020 then -> state RUN, pc=16'h0020.
- imem_rdy=0 for 3 cycles at pc=4 -> three NOP/valid=0 entries; pc=4; fetch_cnt unchanged; on imem_rdy=1, instruction at 4 is delivered.
- pc=16'hFFFF with imem_rdy=1 -> pc wraps to 0 and IF_ID_pc_plus1=0. Also: assert rst mid-stall in HALTED -> all reset values restored on the next edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read port, and holds the IF/ID register.
// Latency: imem_data reaches IF_ID_instr one cycle after it is returned; a redirect target is fetched on the next cycle.
// Backpressure: stall holds the PC and IF/ID; imem_rdy=0 holds the PC and injects a NOP bubble; HLT stops fetching.
//
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   imem_addr/imem_re    - instruction-memory request (combinational from pc/state)
//   imem_data/imem_rdy   - instruction-memory response
//   stall                - decode-stage load-use bubble
//   redirect/redirect_pc - downstream branch/JAL/JR resolution
//   pc                   - current fetch PC
//   IF_ID_*              - pipeline register towards decode
//   halted               - high once a HLT has been accepted into IF/ID
//   fetch_cnt            - number of instructions delivered with valid=1
module if_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'hB000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_re,
    input  logic [15:0] imem_data,
    input  logic        imem_rdy,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc,
    output logic [15:0] IF_ID_instr,
    output logic [15:0] IF_ID_pc_plus1,
    output logic        IF_ID_valid,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state;

    // HLT is identified by its opcode nibble alone.
    logic is_hlt;
    assign is_hlt = (imem_data[15:12] == 4'b1111);

    assign imem_addr = pc;
    assign imem_re   = (state == RUN);
    assign halted    = (state == HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_pc_plus1 <= 16'h0000;
            IF_ID_valid    <= 1'b0;
            fetch_cnt      <= 16'h0000;
            state          <= RUN;
        end else if (redirect) begin
            // Redirect wins over stall and squashes any wrong-path HLT,
            // both the one sitting in IF/ID and one arriving this cycle.
            pc             <= redirect_pc;
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_valid    <= 1'b0;
            state          <= RUN;
        end else if (stall) begin
            // Hold everything; data returned this cycle is dropped and
            // refetched from the same pc once the stall clears.
        end else if (state == HALTED) begin
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_valid    <= 1'b0;
        end else if (!imem_rdy) begin
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_valid    <= 1'b0;
        end else begin
            IF_ID_instr    <= imem_data;
            IF_ID_pc_plus1 <= pc + 16'd1;
            IF_ID_valid    <= 1'b1;
            fetch_cnt      <= fetch_cnt + 16'd1;
            if (is_hlt) begin
                state      <= HALTED;
            end else begin
                pc         <= pc + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then randomized traffic,
// all checked each cycle against a behavioural fetch model.
module tb_if_stage;

    localparam logic [15:0] NOP = 16'hB000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_re;
    logic [15:0] imem_data;
    logic        imem_rdy;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic [15:0] IF_ID_instr;
    logic [15:0] IF_ID_pc_plus1;
    logic        IF_ID_valid;
    logic        halted;
    logic [15:0] fetch_cnt;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_re       (imem_re),
        .imem_data     (imem_data),
        .imem_rdy      (imem_rdy),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .pc            (pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_pc_plus1(IF_ID_pc_plus1),
        .IF_ID_valid   (IF_ID_valid),
        .halted        (halted),
        .fetch_cnt     (fetch_cnt)
    );

    // Behavioural model: architectural view of the fetch stage.
    logic [15:0] m_pc, m_instr, m_ppc, m_cnt;
    logic        m_valid, m_halt;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 16'h0000; m_instr = NOP; m_ppc = 16'h0000;
            m_valid = 1'b0; m_cnt = 16'h0000; m_halt = 1'b0;
        end else if (redirect) begin
            m_pc = redirect_pc; m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
        end else if (stall) begin
            // nothing changes
        end else if (m_halt || !imem_rdy) begin
            m_instr = NOP; m_valid = 1'b0;
        end else begin
            m_instr = imem_data;
            m_ppc   = 16'((32'(m_pc) + 1) % 65536);
            m_valid = 1'b1;
            m_cnt   = 16'((32'(m_cnt) + 1) % 65536);
            if (imem_data[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = 16'((32'(m_pc) + 1) % 65536);
        end
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Single compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pc",        pc,                      m_pc);
            cmp("imem_addr", imem_addr,               m_pc);
            cmp("imem_re",   {15'd0, imem_re},        {15'd0, !m_halt});
            cmp("halted",    {15'd0, halted},         {15'd0, m_halt});
            cmp("instr",     IF_ID_instr,             m_instr);
            cmp("pc_plus1",  IF_ID_pc_plus1,          m_ppc);
            cmp("valid",     {15'd0, IF_ID_valid},    {15'd0, m_valid});
            cmp("fetch_cnt", fetch_cnt,               m_cnt);
        end
    end

    task automatic drive(input logic r, input logic st, input logic rd, input logic [15:0] rpc,
                         input logic rdy, input logic [15:0] d);
        rst = r; stall = st; redirect = rd; redirect_pc = rpc; imem_rdy = rdy; imem_data = d;
    endtask

    // One clock: inputs were set at a falling edge, return at the next falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_fetch(input logic [15:0] d);
        drive(0, 0, 0, 16'h0, 1, d); cyc();
    endtask

    task automatic jump(input logic [15:0] t);
        drive(0, 0, 1, t, 0, 16'h0); cyc();
    endtask

    initial begin
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        cyc();
        chk_en = 1'b1;
        // Reset state pinned to literals.
        cmp("lit_rst_pc",    pc, 16'h0000);
        cmp("lit_rst_instr", IF_ID_instr, 16'hB000);
        cmp("lit_rst_valid", {15'd0, IF_ID_valid}, 16'd0);
        cmp("lit_rst_cnt",   fetch_cnt, 16'd0);
        cmp("lit_rst_re",    {15'd0, imem_re}, 16'd1);

        // Three straight fetches.
        idle_fetch(16'h0123);
        cmp("lit_f1_instr", IF_ID_instr, 16'h0123);
        cmp("lit_f1_ppc",   IF_ID_pc_plus1, 16'd1);
        idle_fetch(16'h2456);
        cmp("lit_f2_ppc",   IF_ID_pc_plus1, 16'd2);
        idle_fetch(16'h3789);
        cmp("lit_f3_instr", IF_ID_instr, 16'h3789);
        cmp("lit_f3_ppc",   IF_ID_pc_plus1, 16'd3);
        cmp("lit_f3_pc",    pc, 16'd3);
        cmp("lit_f3_cnt",   fetch_cnt, 16'd3);

        // Reach pc=5, then stall for two cycles.
        idle_fetch(16'h1000);
        idle_fetch(16'h1001);
        drive(0, 1, 0, 16'h0, 1, 16'h2222); cyc(); cyc();
        cmp("lit_stall_pc",    pc, 16'd5);
        cmp("lit_stall_instr", IF_ID_instr, 16'h1001);
        cmp("lit_stall_ppc",   IF_ID_pc_plus1, 16'd5);
        cmp("lit_stall_cnt",   fetch_cnt, 16'd5);
        idle_fetch(16'h4444);
        cmp("lit_resume_ppc",  IF_ID_pc_plus1, 16'd6);

        // Redirect beats a simultaneous stall at pc=7.
        idle_fetch(16'h5555);
        cmp("lit_pc7", pc, 16'd7);
        drive(0, 1, 1, 16'h0040, 1, 16'h6666); cyc();
        cmp("lit_redir_pc",    pc, 16'h0040);
        cmp("lit_redir_instr", IF_ID_instr, 16'hB000);
        cmp("lit_redir_valid", {15'd0, IF_ID_valid}, 16'd0);

        // HLT at pc=9.
        jump(16'h0009);
        idle_fetch(16'hF000);
        cmp("lit_hlt_instr",  IF_ID_instr, 16'hF000);
        cmp("lit_hlt_valid",  {15'd0, IF_ID_valid}, 16'd1);
        cmp("lit_hlt_pc",     pc, 16'd9);
        cmp("lit_hlt_halted", {15'd0, halted}, 16'd1);
        cmp("lit_hlt_re",     {15'd0, imem_re}, 16'd0);
        idle_fetch(16'h1111);
        cmp("lit_halt_nop",   IF_ID_instr, 16'hB000);
        cmp("lit_halt_valid", {15'd0, IF_ID_valid}, 16'd0);
        jump(16'h0020);
        cmp("lit_unhalt_pc",  pc, 16'h0020);
        cmp("lit_unhalt",     {15'd0, halted}, 16'd0);

        // Memory wait at pc=4.
        jump(16'h0004);
        begin
            logic [15:0] c0;
            c0 = fetch_cnt;
            for (int i = 0; i < 3; i++) begin
                drive(0, 0, 0, 16'h0, 0, 16'hDEAD); cyc();
                cmp("lit_miss_valid", {15'd0, IF_ID_valid}, 16'd0);
                cmp("lit_miss_instr", IF_ID_instr, 16'hB000);
                cmp("lit_miss_pc",    pc, 16'd4);
            end
            cmp("lit_miss_cnt", fetch_cnt, c0);
        end
        idle_fetch(16'h7777);
        cmp("lit_miss_done", IF_ID_instr, 16'h7777);
        cmp("lit_miss_ppc",  IF_ID_pc_plus1, 16'd5);

        // PC wrap.
        jump(16'hFFFF);
        idle_fetch(16'h1234);
        cmp("lit_wrap_pc",  pc, 16'h0000);
        cmp("lit_wrap_ppc", IF_ID_pc_plus1, 16'h0000);

        // Stall while halted keeps the HLT, then reset during the stall.
        jump(16'h0009);
        idle_fetch(16'hF123);
        drive(0, 1, 0, 16'h0, 1, 16'h0); cyc();
        cmp("lit_hstall_instr", IF_ID_instr, 16'hF123);
        cmp("lit_hstall_valid", {15'd0, IF_ID_valid}, 16'd1);
        drive(1, 1, 0, 16'h0, 1, 16'h0); cyc();
        cmp("lit_rst2_pc",     pc, 16'h0000);
        cmp("lit_rst2_halted", {15'd0, halted}, 16'd0);
        cmp("lit_rst2_cnt",    fetch_cnt, 16'd0);
        cmp("lit_rst2_instr",  IF_ID_instr, 16'hB000);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 99) < 6) d[15:12] = 4'hF;
            else if (d[15:12] == 4'hF) d[15:12] = 4'h3;
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10,
                  ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom),
                  $urandom_range(0, 99) < 75,
                  d);
            cyc();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
